bpu_btb: RTL and testbench
==========================

Name: bpu_btb

Overview:
- Branch predictor sitting directly upstream of the fetch PC-select mux.
- Supplies pred_taken / pre_pc to the selector, honouring the MIPS delay slot: a branch predicted taken at fetch PC X redirects only after the delay slot (X+4) has been fetched.
- Direct-mapped BTB with per-entry 2-bit saturating counters, trained from the execute stage.

Parameters:
- ENTRIES, 64, number of BTB entries; must be a power of 2.
- IDX_W, $clog2(ENTRIES), index width taken from pc[IDX_W+1:2].
- TAG_W, 30-IDX_W, tag width taken from pc[31:IDX_W+2].

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- f_pc  in  32  PC currently being fetched.
- f_accept  in  1  fetch of f_pc is accepted this cycle (valid & ~stall).
- flush  in  1  redirect from branch/exception/eret/icache; kills the pending prediction.
- pred_taken  out  1  redirect the next fetch to pre_pc.
- pre_pc  out  32  predicted target.
- f_pred_hit  out  1  lookup at f_pc hit and predicts taken (combinational; carried down the pipe for misprediction checking).
- upd_valid  in  1  training write from execute.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target.

Behaviour:
- Storage per entry: valid, tag[TAG_W], target[32], ctr[2].
- Reset clears every valid bit, pending, pend_target and all outputs.
- Lookup is combinational on f_pc.
  - hit = valid[idx] & tag match.
  - f_pred_hit = hit & ctr[1].
- Lookup reads pre-update contents: an update in the same cycle to the same index is not visible until the next cycle.
- Pending FSM, two states:
  - IDLE: when f_accept & f_pred_hit & ~flush, go to ARMED and latch pend_target = target[idx].
  - ARMED: pred_taken = 1 and pre_pc = pend_target, combinationally.
    - f_accept & ~flush means the delay slot has been fetched: return to IDLE.
    - If that same accepted delay-slot PC also hits, it does not arm. A branch in a delay slot is not predicted.
    - While ~f_accept (stall), stay ARMED and hold the outputs stable.
  - flush in any state forces IDLE next cycle. In the flush cycle itself pred_taken still reflects ARMED; the downstream selector gives flush priority.
- In IDLE: pred_taken = 0, pre_pc = 0.
- Update, on the clock edge when upd_valid:
  - Entry present (valid & tag match):
    - upd_taken: ctr saturating +1 (max 3), target <= upd_target.
    - ~upd_taken: ctr saturating -1 (min 0).
  - Entry absent and upd_taken: allocate/replace with valid=1, tag, target, ctr=2'b10.
  - Entry absent and ~upd_taken: no write.
- Counter arithmetic is 2-bit unsigned and never wraps: 3+1 stays 3, 0-1 stays 0.
- Asserting reset mid-operation clears the FSM and valid bits immediately (asynchronous). Outputs are 0 while reset is high.

Decomposition:
- Shared package gets:
  - btb_entry_t struct {valid, tag, target, ctr}.
  - bpu_state_t enum {BPU_IDLE, BPU_ARMED}.
  - Counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
- One natural sub-module: sat_ctr2, a pure combinational function (old ctr, taken) -> new ctr, reused by a future BHT.
- The entry array stays in bpu_btb as flops with an async reset on the valid bits only.

Test Plan:
- Reset, then fetch 0xBFC00000..0xBFC00010 with f_accept=1 -> f_pred_hit=0 and pred_taken=0 every cycle.
- Update pc=0x80000100, taken, target=0x80000200. Then fetch 0x80000100 then 0x80000104 -> f_pred_hit=1 at 0x...100; pred_taken=1 with pre_pc=0x80000200 during the 0x...104 cycle; 0 afterwards.
- ARMED with f_accept held low for 3 cycles -> pred_taken=1 and pre_pc=0x80000200 held all 3 cycles; cleared one cycle after f_accept=1.
- ARMED, assert flush -> pred_taken=0 next cycle even without f_accept; no stale redirect afterwards.
- Counter training on pc 0x80000100:
  - Two not-taken updates -> ctr 2->1->0; lookup at 0x80000100 gives f_pred_hit=0.
  - Then four taken updates -> ctr saturates at 3 and hits again.
  - A not-taken update to an absent pc (0x80000300) allocates nothing.
- Aliasing: entry for 0x80000100 present; taken update to 0x80000100 + ENTRIES*4 -> entry replaced; original pc misses. Same-cycle update + lookup on that index -> lookup returns the old entry.

Source files
------------

// File: rtl/bpu_btb_pkg.sv
// ----------------------------------------------------------------------------
// bpu_btb_pkg : shared types and constants for the branch predictor. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bpu_btb_pkg;

  localparam int BTB_TAG_MAX_W = 30;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Tags are carried at the widest possible size and zero-extended.
  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [31:0]              target;
    logic [1:0]               ctr;
  } btb_entry_t;

  typedef enum logic [0:0] {
    BPU_IDLE  = 1'b0,
    BPU_ARMED = 1'b1
  } bpu_state_t;

endpackage

`default_nettype wire

// File: rtl/bpu_btb_if.sv
// ----------------------------------------------------------------------------
// bpu_btb_if : fetch-side lookup and execute-side training bus. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bpu_btb_if;
  logic [31:0] f_pc;
  logic        f_accept;
  logic        flush;
  logic        pred_taken;
  logic [31:0] pre_pc;
  logic        f_pred_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output f_pc, f_accept, flush, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_taken, pre_pc, f_pred_hit
  );

  modport slave (
    input  f_pc, f_accept, flush, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_taken, pre_pc, f_pred_hit
  );
endinterface

`default_nettype wire

// File: rtl/bpu_btb_sat_ctr2.sv
// ----------------------------------------------------------------------------
// sat_ctr2 : 2-bit saturating direction counter step. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sat_ctr2
  import bpu_btb_pkg::*;
(
  input  logic [1:0] ctr_in,
  input  logic       taken,
  output logic [1:0] ctr_out
);

  always_comb begin
    ctr_out = ctr_in;
    if (taken) begin
      if (ctr_in != CTR_ST) ctr_out = ctr_in + 2'd1;
    end else begin
      if (ctr_in != CTR_SNT) ctr_out = ctr_in - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bpu_btb.sv
// ----------------------------------------------------------------------------
// bpu_btb : direct-mapped BTB with delay-slot-aware taken redirect. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W
) (
  input  logic      clk,
  input  logic      reset,
  bpu_btb_if.slave  bus
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  bpu_state_t  state_q, state_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic [IDX_W-1:0] f_idx, upd_idx;
  logic [TAG_W-1:0] f_tag, upd_tag;
  btb_entry_t       rd_entry, upd_old, wr_entry;
  logic             f_hit, f_taken_hit, upd_present, wr_en;
  logic [1:0]       ctr_stepped;
  logic             unused_bits;

  assign f_idx   = bus.f_pc[IDX_W+1:2];
  assign f_tag   = bus.f_pc[31:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[31:IDX_W+2];

  // Lookup reads the registered array, so a same-cycle write is invisible.
  always_comb begin
    rd_entry.valid  = valid_q[f_idx];
    rd_entry.tag    = BTB_TAG_MAX_W'(tag_q[f_idx]);
    rd_entry.target = target_q[f_idx];
    rd_entry.ctr    = ctr_q[f_idx];
    upd_old.valid   = valid_q[upd_idx];
    upd_old.tag     = BTB_TAG_MAX_W'(tag_q[upd_idx]);
    upd_old.target  = target_q[upd_idx];
    upd_old.ctr     = ctr_q[upd_idx];
  end

  assign f_hit       = rd_entry.valid && (rd_entry.tag == BTB_TAG_MAX_W'(f_tag));
  assign f_taken_hit = f_hit && rd_entry.ctr[1];
  assign upd_present = upd_old.valid && (upd_old.tag == BTB_TAG_MAX_W'(upd_tag));

  sat_ctr2 u_sat_ctr2 (
    .ctr_in  (upd_old.ctr),
    .taken   (bus.upd_taken),
    .ctr_out (ctr_stepped)
  );

  // Absent + not-taken never allocates; absent + taken starts weakly taken.
  always_comb begin
    wr_en           = bus.upd_valid && (upd_present || bus.upd_taken);
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = BTB_TAG_MAX_W'(upd_tag);
    wr_entry.target = bus.upd_taken ? bus.upd_target : upd_old.target;
    wr_entry.ctr    = upd_present ? ctr_stepped : CTR_WT;
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (wr_en) begin
      valid_d[upd_idx]  = wr_entry.valid;
      tag_d[upd_idx]    = wr_entry.tag[TAG_W-1:0];
      target_d[upd_idx] = wr_entry.target;
      ctr_d[upd_idx]    = wr_entry.ctr;
    end
  end

  // A hit in the delay slot itself (ARMED) never re-arms.
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    case (state_q)
      BPU_IDLE: begin
        if (bus.f_accept && f_taken_hit && !bus.flush) begin
          state_d       = BPU_ARMED;
          pend_target_d = rd_entry.target;
        end
      end
      BPU_ARMED: begin
        if (bus.flush || bus.f_accept) state_d = BPU_IDLE;
      end
      default: state_d = BPU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BPU_IDLE;
      pend_target_q <= '0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      valid_q       <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

  assign bus.f_pred_hit = f_taken_hit;
  assign bus.pred_taken = (state_q == BPU_ARMED);
  assign bus.pre_pc     = (state_q == BPU_ARMED) ? pend_target_q : 32'h0;

  assign unused_bits = ^{bus.f_pc[1:0], bus.upd_pc[1:0], rd_entry.ctr[0]};

endmodule

`default_nettype wire

// File: tb/tb_bpu_btb.sv
// ----------------------------------------------------------------------------
// tb_bpu_btb : directed self-checking bench for bpu_btb. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bpu_btb;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bpu_btb_if bus ();

  bpu_btb #(.ENTRIES(64)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic acc);
    bus.f_pc     = pc;
    bus.f_accept = acc;
    #1;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.f_accept   = 1'b0;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_taken  = taken;
    bus.upd_target = tgt;
    tick();
    bus.upd_valid  = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic exp_hit);
    fetch(pc, 1'b0);
    check(tag, 32'(bus.f_pred_hit), 32'(exp_hit));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.f_pc = '0; bus.f_accept = 1'b0; bus.flush = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("rst_pre_pc", bus.pre_pc, 32'h0);
    check("rst_hit", 32'(bus.f_pred_hit), 32'd0);
    reset = 1'b0;
    tick();

    // Cold BTB: boot fetch never predicts
    for (int i = 0; i < 5; i++) begin
      fetch(32'hBFC0_0000 + 32'(i * 4), 1'b1);
      check("cold_hit", 32'(bus.f_pred_hit), 32'd0);
      check("cold_taken", 32'(bus.pred_taken), 32'd0);
      tick();
    end
    fetch(32'h0, 1'b0);

    // Allocate and redirect after the delay slot
    train(32'h8000_0100, 1'b1, 32'h8000_0200);
    fetch(32'h8000_0100, 1'b1);
    check("br_hit", 32'(bus.f_pred_hit), 32'd1);
    check("br_no_early_redirect", 32'(bus.pred_taken), 32'd0);
    tick();
    fetch(32'h8000_0104, 1'b1);
    check("ds_taken", 32'(bus.pred_taken), 32'd1);
    check("ds_pre_pc", bus.pre_pc, 32'h8000_0200);
    tick();
    fetch(32'h8000_0200, 1'b1);
    check("after_taken", 32'(bus.pred_taken), 32'd0);
    check("after_pre_pc", bus.pre_pc, 32'h0);
    tick();

    // Stall in ARMED holds the redirect
    fetch(32'h8000_0100, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      fetch(32'h8000_0104, 1'b0);
      check("stall_taken", 32'(bus.pred_taken), 32'd1);
      check("stall_pre_pc", bus.pre_pc, 32'h8000_0200);
      tick();
    end
    fetch(32'h8000_0104, 1'b1);
    check("stall_release_taken", 32'(bus.pred_taken), 32'd1);
    tick();
    fetch(32'h8000_0200, 1'b0);
    check("stall_cleared", 32'(bus.pred_taken), 32'd0);
    tick();

    // Branch in a delay slot does not re-arm
    fetch(32'h8000_0100, 1'b1);
    tick();
    fetch(32'h8000_0100, 1'b1);
    check("ds_branch_hit", 32'(bus.f_pred_hit), 32'd1);
    check("ds_branch_taken", 32'(bus.pred_taken), 32'd1);
    tick();
    fetch(32'h8000_0200, 1'b0);
    check("ds_branch_no_rearm", 32'(bus.pred_taken), 32'd0);
    tick();

    // Flush kills a pending prediction
    fetch(32'h8000_0100, 1'b1);
    tick();
    fetch(32'h8000_0104, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("flush_cycle_taken", 32'(bus.pred_taken), 32'd1);
    tick();
    bus.flush = 1'b0;
    fetch(32'h8000_0104, 1'b0);
    check("flush_next_taken", 32'(bus.pred_taken), 32'd0);
    check("flush_next_pre_pc", bus.pre_pc, 32'h0);
    tick();
    fetch(32'h8000_0104, 1'b1);
    check("flush_no_stale", 32'(bus.pred_taken), 32'd0);
    tick();
    // Flush in IDLE blocks arming on a hit
    bus.flush = 1'b1;
    fetch(32'h8000_0100, 1'b1);
    tick();
    bus.flush = 1'b0;
    fetch(32'h8000_0104, 1'b0);
    check("flush_idle_no_arm", 32'(bus.pred_taken), 32'd0);
    tick();

    // Counter training: 2 -> 1 -> 0 -> 0, then up to saturation
    train(32'h8000_0100, 1'b0, 32'h0); probe("ctr_1", 32'h8000_0100, 1'b0);
    train(32'h8000_0100, 1'b0, 32'h0); probe("ctr_0", 32'h8000_0100, 1'b0);
    train(32'h8000_0100, 1'b0, 32'h0); probe("ctr_floor", 32'h8000_0100, 1'b0);
    train(32'h8000_0100, 1'b1, 32'h8000_0240); probe("ctr_up1", 32'h8000_0100, 1'b0);
    train(32'h8000_0100, 1'b1, 32'h8000_0240); probe("ctr_up2", 32'h8000_0100, 1'b1);
    train(32'h8000_0100, 1'b1, 32'h8000_0240); probe("ctr_up3", 32'h8000_0100, 1'b1);
    train(32'h8000_0100, 1'b1, 32'h8000_0240); probe("ctr_sat", 32'h8000_0100, 1'b1);
    fetch(32'h8000_0100, 1'b1);
    tick();
    fetch(32'h8000_0104, 1'b1);
    check("new_target", bus.pre_pc, 32'h8000_0240);
    tick();
    train(32'h8000_0100, 1'b0, 32'h0); probe("ctr_sat_down", 32'h8000_0100, 1'b1);
    train(32'h8000_0100, 1'b0, 32'h0); probe("ctr_sat_down2", 32'h8000_0100, 1'b0);

    // Not-taken to an absent pc allocates nothing
    train(32'h8000_0300, 1'b0, 32'h8000_0500);
    probe("absent_nt", 32'h8000_0300, 1'b0);

    // Aliasing replacement (64 entries -> +0x100)
    train(32'h8000_0100, 1'b1, 32'h8000_0240); probe("pre_alias", 32'h8000_0100, 1'b1);
    train(32'h8000_0200, 1'b1, 32'h8000_0400);
    probe("alias_new_hit", 32'h8000_0200, 1'b1);
    probe("alias_old_miss", 32'h8000_0100, 1'b0);

    // Same-cycle update and lookup sees the old contents
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h8000_0100;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h8000_0600;
    probe("same_cycle_old_hit", 32'h8000_0200, 1'b1);
    probe("same_cycle_new_miss", 32'h8000_0100, 1'b0);
    tick();
    bus.upd_valid = 1'b0;
    probe("after_replace_hit", 32'h8000_0100, 1'b1);
    probe("after_replace_miss", 32'h8000_0200, 1'b0);
    fetch(32'h8000_0100, 1'b1);
    tick();
    fetch(32'h8000_0104, 1'b0);
    check("replace_target", bus.pre_pc, 32'h8000_0600);

    // Asynchronous reset while ARMED
    reset = 1'b1;
    #1;
    check("async_rst_taken", 32'(bus.pred_taken), 32'd0);
    check("async_rst_pre_pc", bus.pre_pc, 32'h0);
    probe("async_rst_hit", 32'h8000_0100, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    probe("post_rst_miss", 32'h8000_0100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
